// File: rtl/stream_width_packer_pkg.sv
// Shared sizing helpers for the narrow-to-wide stream packer.
// Sizes depend on per-instance parameters, so they are provided as constant functions.
package stream_width_packer_pkg;

    localparam int DEFAULT_IN_WIDTH = 32;
    localparam int DEFAULT_RATIO    = 4;

    function automatic int out_width(input int in_width, input int ratio);
        return in_width * ratio;
    endfunction

    function automatic int count_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    // Clamped to 1 so a RATIO==1 instance still has a legal lane counter.
    function automatic int lane_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_pack_hold_reg.sv
// Output holding register: loads a completed word, holds it until drained,
// and reloads in the same cycle as a drain for full throughput.
module stream_pack_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    logic drain;

    assign drain = valid & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_width_packer.sv
// Packs RATIO narrow words into one wide word (lane 0 in LSBs) and writes it
// to a downstream FIFO; if_last flushes a partial word early.
module stream_width_packer
    import stream_width_packer_pkg::*;
#(
    parameter int IN_WIDTH = DEFAULT_IN_WIDTH,
    parameter int RATIO    = DEFAULT_RATIO
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic                                 if_full_n,
    input  logic                                 if_write_ce,
    input  logic                                 if_write,
    input  logic [IN_WIDTH-1:0]                  if_din,
    input  logic                                 if_last,
    input  logic                                 out_full_n,
    output logic                                 out_write,
    output logic [out_width(IN_WIDTH,RATIO)-1:0] out_din,
    output logic                                 out_last,
    output logic [count_width(RATIO)-1:0]        out_count
);

    localparam int OUT_WIDTH   = out_width(IN_WIDTH, RATIO);
    localparam int COUNT_WIDTH = count_width(RATIO);
    localparam int LANE_WIDTH  = lane_width(RATIO);
    localparam int HOLD_WIDTH  = OUT_WIDTH + 1 + COUNT_WIDTH;

    logic [RATIO-1:0][IN_WIDTH-1:0] acc, acc_next;
    logic [LANE_WIDTH-1:0]          cnt;
    logic                           accept, complete;
    logic [COUNT_WIDTH-1:0]         lane_count;
    logic [HOLD_WIDTH-1:0]          hold_din, hold_dout;

    // Back-pressure depends only on the registered valid, never on if_write.
    assign if_full_n  = ~out_write | out_full_n;
    assign accept     = if_write & if_write_ce & if_full_n;
    assign complete   = accept & ((cnt == LANE_WIDTH'(RATIO - 1)) | if_last);
    assign lane_count = COUNT_WIDTH'(cnt) + COUNT_WIDTH'(1);

    // Upper lanes are still zero from the last clear, so a flush pads with zeros.
    for (genvar l = 0; l < RATIO; l++) begin : g_lane
        assign acc_next[l] = (accept && cnt == LANE_WIDTH'(l)) ? if_din : acc[l];
    end

    always_ff @(posedge clk) begin
        if (reset || complete) begin
            cnt <= '0;
            acc <= '0;
        end else if (accept) begin
            cnt <= cnt + LANE_WIDTH'(1);
            acc <= acc_next;
        end
    end

    assign hold_din = {if_last, lane_count, acc_next};

    stream_pack_hold_reg #(
        .WIDTH(HOLD_WIDTH)
    ) u_hold (
        .clk  (clk),
        .reset(reset),
        .load (complete),
        .ready(out_full_n),
        .din  (hold_din),
        .valid(out_write),
        .dout (hold_dout)
    );

    assign {out_last, out_count, out_din} = hold_dout;

endmodule

// File: doc/stream_width_packer.md
# stream_width_packer

Upstream feeder for the relay station / almost-full FIFO chain. It packs `RATIO` consecutive narrow stream words into one wide word and writes that wide word into the downstream FIFO's write port. An `if_last` input flushes a partially filled word early. Each output word carries a lane count and a last flag.

## Interface

**Parameters**
- `IN_WIDTH`, default 32: width of one input word.
- `RATIO`, default 4: input words per output word; must be ≥ 1.

**Ports**
- One clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `if_full_n`  out  1  upstream may write this cycle.
- `if_write_ce`  in  1  write clock-enable; qualifies `if_write`.
- `if_write`  in  1  upstream write strobe.
- `if_din`  in  `IN_WIDTH`  input word.
- `if_last`  in  1  this input word ends a packet; sampled with the write.
- `out_full_n`  in  1  downstream FIFO can accept; connects to the FIFO's `if_full_n`.
- `out_write`  out  1  output word valid; connects to the FIFO's `if_write`.
- `out_din`  out  `IN_WIDTH*RATIO`  packed word; lane 0 is in the LSBs.
- `out_last`  out  1  packed word ends a packet.
- `out_count`  out  `$clog2(RATIO+1)`  number of valid lanes, from 1 to `RATIO`.

## Operation

**Handshake terms**
- `accept = if_write & if_write_ce & if_full_n`.
- `drain = out_write & out_full_n`.

**State**
- Accumulator register, `IN_WIDTH*RATIO` bits.
- Lane counter `cnt`, range 0..`RATIO`-1.
- Output holding register: data, last, count, and a valid bit that drives `out_write`.

**Accepting a word**
- On `accept`, `if_din` is written into lane `cnt`.
- A word completes when `accept & (cnt == RATIO-1 | if_last)`.
- Otherwise `cnt` increments.

**On completion**
- Copy the accumulator, including the incoming lane, into the holding register.
- Set valid, `out_last = if_last`, `out_count = cnt+1`.
- Clear `cnt` and the accumulator.
- Lanes above `cnt` are zero in the copied word.

**Back-pressure**
- `if_full_n = ~out_write | out_full_n`.
- This is combinational from registered valid and `out_full_n`; there is no path from `if_write`.
- Accumulation therefore stalls only while a completed word is held undrained.

**Drain and concurrency**
- On `drain` with no completion in the same cycle: clear valid.
- Completion and drain in the same cycle: the holding register reloads and valid stays 1, giving full throughput.
- While valid is set and `drain` is 0: `out_din`, `out_last` and `out_count` are held stable.

**Degenerate case**
- `RATIO == 1`: every accept completes. The block is a one-cycle registered stage with `out_count = 1`.

**Reset**
- Reset at any time discards the partial word and any held word.
- `cnt = 0`, accumulator = 0, `out_write = 0`, `out_din = 0`, `out_last = 0`, `out_count = 0`.
- `if_full_n = 1` from the first cycle after reset.

## Timing
- Latency: a word completing at edge t gives `out_write = 1` in cycle t+1.
- Sustained rate: one input word per cycle while `out_full_n = 1`.
- `out_write` is registered. It does not depend on `out_full_n` and never deasserts without a drain.
- `if_write` while `if_full_n = 0`, or with `if_write_ce = 0`, is ignored: no state change.
- `if_last` with `cnt == RATIO-1` is a normal full completion with `out_last = 1`.

## Structure
- Shared package holds:
  - `OUT_WIDTH = IN_WIDTH*RATIO`
  - `COUNT_WIDTH = $clog2(RATIO+1)`
  - `LANE_WIDTH = $clog2(RATIO)`, clamped to a minimum of 1
- One sub-module, `stream_pack_hold_reg`: the output holding register with its valid/drain/reload logic. It is parameterised on payload width, covering data + last + count.
- Lane insertion and `cnt` control stay in the top level.

## Test plan
All scenarios use `IN_WIDTH = 8`, `RATIO = 4` unless stated.

1. **Reset.** Release reset → `out_write = 0`, `out_din = 0`, `out_count = 0`, `if_full_n = 1`.
2. **Full word.** Write 0x11, 0x22, 0x33, 0x44 on consecutive cycles with `out_full_n = 1` → one cycle after the 4th accept: `out_write = 1`, `out_din = 0x44332211`, `out_count = 4`, `out_last = 0`.
3. **Partial flush.** Write 0xAA, then 0xBB with `if_last = 1` → `out_din = 0x0000BBAA`, `out_count = 2`, `out_last = 1`. The next word then starts at lane 0.
4. **Back-pressure.**
   - Hold `out_full_n = 0` with a word pending and keep writing → `if_full_n = 0`, output fields stable, no accept.
   - Release → drain, then accepts resume with no lost or duplicated words.
5. **Throughput and ignored writes.**
   - 8 back-to-back writes 0x01..0x08 → outputs 0x04030201 and 0x08070605, 4 cycles apart, `if_full_n` constantly 1.
   - A write with `if_write_ce = 0` is ignored.
6. **Reset mid-operation.** Assert reset after 2 accepted words, then write 0x51..0x54 → single output 0x54535251 with `out_count = 4`.
